scroll_window_gen: RTL and testbench

Message buffer and scroll sequencer feeding the 4-digit display scan stage. Stores up to MAX_LEN 4-bit character codes, advances a circular 4-character window once per prescaled tick, and presents the window as four digit codes (first..fourth) to the multiplexer/decoder downstream. It replaces derived slow clocks with a single-clock enable, so the whole path runs on `clk`.

---
 rtl/scroll_window_gen_pkg.sv | 34 +++
 rtl/scroll_window_gen_if.sv | 60 ++++++
 rtl/scroll_window_gen_tick_prescaler.sv | 34 +++
 rtl/scroll_window_gen.sv | 116 +++++++++++
 tb/tb_scroll_window_gen.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scroll_window_gen_pkg.sv
// Shared constants for the scroll/display path: code width, the blank code
// and the character codes the segment decoder understands. The decoder must
// render BLANK_CODE as all segments off.
package scroll_pkg;

  localparam int CODE_W = 4;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t BLANK_CODE = 4'hF;

  localparam code_t CH_0     = 4'h0;
  localparam code_t CH_1     = 4'h1;
  localparam code_t CH_2     = 4'h2;
  localparam code_t CH_3     = 4'h3;
  localparam code_t CH_4     = 4'h4;
  localparam code_t CH_5     = 4'h5;
  localparam code_t CH_6     = 4'h6;
  localparam code_t CH_7     = 4'h7;
  localparam code_t CH_8     = 4'h8;
  localparam code_t CH_9     = 4'h9;
  localparam code_t CH_A     = 4'hA;
  localparam code_t CH_B     = 4'hB;
  localparam code_t CH_C     = 4'hC;
  localparam code_t CH_D     = 4'hD;
  localparam code_t CH_E     = 4'hE;
  localparam code_t CH_BLANK = BLANK_CODE;

  typedef enum logic {
    SCROLL_LEFT  = 1'b0,
    SCROLL_RIGHT = 1'b1
  } scroll_dir_e;

endpackage

// File: rtl/scroll_window_gen_if.sv
// Host/display bundle for scroll_window_gen. The dir signal exists only when
// SCROLL_DIR_EN is defined.
interface scroll_window_gen_if
  import scroll_pkg::*;
#(
  parameter int MAX_LEN = 16
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic             wr_en;
  code_t            wr_data;
  logic             clr;
  logic             run;
`ifdef SCROLL_DIR_EN
  logic             dir;
`endif
  code_t            first;
  code_t            second;
  code_t            third;
  code_t            fourth;
  logic [LEN_W-1:0] len;
  logic             full;
  logic             tick;

  modport master (
    output wr_en,
    output wr_data,
    output clr,
    output run,
`ifdef SCROLL_DIR_EN
    output dir,
`endif
    input  first,
    input  second,
    input  third,
    input  fourth,
    input  len,
    input  full,
    input  tick
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  clr,
    input  run,
`ifdef SCROLL_DIR_EN
    input  dir,
`endif
    output first,
    output second,
    output third,
    output fourth,
    output len,
    output full,
    output tick
  );

endinterface

// File: rtl/scroll_window_gen_tick_prescaler.sv
// Single-clock enable generator: divides clk by TICK_DIV while en is high.
// tick is a combinational strobe in the last count cycle, so a consumer can
// update its state on the same edge the counter wraps. The count freezes
// while en is low and clears on reset or clr.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == LAST);

  // Divider counter: wraps at TICK_DIV-1, holds while disabled
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && !reset && !clr && at_last;

endmodule

// File: rtl/scroll_window_gen.sv
// scroll_window_gen: message buffer plus circular 4-character scroll window
// for the 4-digit display. One clock; scrolling is paced by tick_prescaler.
// Optional feature macro: SCROLL_DIR_EN (adds the dir input and right scroll).
module scroll_window_gen
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_LEN  = 16
) (
  input  logic                clk,
  input  logic                reset,
  scroll_window_gen_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int POS_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef logic [LEN_W-1:0] len_t;
  typedef logic [POS_W-1:0] pos_t;

  code_t msg [MAX_LEN];
  len_t  len_q;
  pos_t  pos_q;
  logic  full_q;
  logic  tick_q;

  logic  step;
  logic  scroll_en;
  logic  wr_ok;
  pos_t  pos_next;
  pos_t  idx1, idx2, idx3;

  function automatic pos_t wrap_inc(input pos_t p, input len_t l);
    return ((len_t'(p) + len_t'(1)) == l) ? '0 : p + POS_W'(1);
  endfunction

`ifdef SCROLL_DIR_EN
  function automatic pos_t wrap_dec(input pos_t p, input len_t l);
    return (p == '0) ? POS_W'(l - len_t'(1)) : p - POS_W'(1);
  endfunction
`endif

  assign scroll_en = bus.run && (len_q != '0);
  assign wr_ok     = bus.wr_en && !full_q && !bus.clr;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .en    (scroll_en),
    .tick  (step)
  );

  // Next window start, wrapped against the pre-write length
  always_comb begin
    pos_next = wrap_inc(pos_q, len_q);
`ifdef SCROLL_DIR_EN
    if (scroll_dir_e'(bus.dir) == SCROLL_RIGHT) begin
      pos_next = wrap_dec(pos_q, len_q);
    end
`endif
  end

  // Length, window position, full flag and tick pulse
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      len_q  <= '0;
      pos_q  <= '0;
      full_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= step;
      if (step) begin
        pos_q <= pos_next;
      end
      if (wr_ok) begin
        len_q  <= len_q + len_t'(1);
        full_q <= ((len_q + len_t'(1)) == len_t'(MAX_LEN));
      end
    end
  end

  // Message storage: append at the current length, contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      msg[POS_W'(len_q)] <= bus.wr_data;
    end
  end

  // Window indices; repeated wrap lets messages shorter than 4 repeat
  assign idx1 = wrap_inc(pos_q, len_q);
  assign idx2 = wrap_inc(idx1, len_q);
  assign idx3 = wrap_inc(idx2, len_q);

  // Registered digit codes, one cycle behind the buffer state
  always_ff @(posedge clk) begin
    if (reset || (len_q == '0)) begin
      bus.fourth <= BLANK_CODE;
      bus.third  <= BLANK_CODE;
      bus.second <= BLANK_CODE;
      bus.first  <= BLANK_CODE;
    end else begin
      bus.fourth <= msg[pos_q];
      bus.third  <= msg[idx1];
      bus.second <= msg[idx2];
      bus.first  <= msg[idx3];
    end
  end

  assign bus.len  = len_q;
  assign bus.full = full_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_scroll_window_gen.sv
// Testbench for scroll_window_gen with TICK_DIV=4, MAX_LEN=16. A behavioural
// model built from modular arithmetic tracks the expected outputs cycle by cycle.
module tb_scroll_window_gen;
  import scroll_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int MAX_LEN  = 16;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  scroll_window_gen_if #(.MAX_LEN(MAX_LEN)) bus ();

  scroll_window_gen #(
    .TICK_DIV (TICK_DIV),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] win;
  assign win = {bus.fourth, bus.third, bus.second, bus.first};

  // Reference model state
  logic [3:0]  m_msg [MAX_LEN];
  int          m_len = 0;
  int          m_pos = 0;
  int          m_cnt = 0;
  logic        m_tick = 1'b0;
  logic        m_full = 1'b0;
  logic [15:0] m_win = 16'hFFFF;

  // Model: evaluates every rising edge from the inputs driven beforehand
  initial begin
    logic d;
    logic stp;
    forever begin
      @(posedge clk);
      d = 1'b0;
`ifdef SCROLL_DIR_EN
      d = bus.dir;
`endif
      if (reset) begin
        m_len = 0; m_pos = 0; m_cnt = 0; m_tick = 1'b0; m_full = 1'b0;
        m_win = 16'hFFFF;
      end else begin
        if (m_len == 0) m_win = 16'hFFFF;
        else m_win = {m_msg[m_pos], m_msg[(m_pos + 1) % m_len],
                      m_msg[(m_pos + 2) % m_len], m_msg[(m_pos + 3) % m_len]};
        if (bus.clr) begin
          m_len = 0; m_pos = 0; m_cnt = 0; m_tick = 1'b0;
        end else begin
          stp = bus.run && (m_len != 0) && (m_cnt == TICK_DIV - 1);
          if (bus.run && m_len != 0) m_cnt = (m_cnt + 1) % TICK_DIV;
          m_tick = stp;
          if (stp) m_pos = d ? (m_pos + m_len - 1) % m_len : (m_pos + 1) % m_len;
          if (bus.wr_en && m_len < MAX_LEN) begin
            m_msg[m_len] = bus.wr_data;
            m_len++;
          end
        end
        m_full = (m_len == MAX_LEN);
      end
    end
  end

  task automatic do_clear();
    @(negedge clk); bus.clr = 1'b1; bus.run = 1'b0;
    @(negedge clk); bus.clr = 1'b0;
  endtask

  task automatic write_seq(input logic [3:0] codes [$]);
    foreach (codes[i]) begin
      @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = codes[i];
    end
    @(negedge clk); bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (bus.tick !== 1'b0) begin
        fails++; $display("FAIL reset_tick cycle %0d got %b exp 0", i, bus.tick);
      end
    end
    tests++;
    if (win !== 16'hFFFF) begin fails++; $display("FAIL reset_win got %h exp ffff", win); end
    tests++;
    if (bus.len !== '0) begin fails++; $display("FAIL reset_len got %0d exp 0", bus.len); end
    tests++;
    if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.full); end
  endtask

  task automatic test_scroll_left();
    logic [15:0] exp_w [5] = '{16'h2345, 16'h3451, 16'h4512, 16'h5123, 16'h1234};
    int since;
    bit got;
    write_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    tests++;
    if (bus.len !== LEN_W'(5)) begin fails++; $display("FAIL left_len got %0d exp 5", bus.len); end
    @(negedge clk);
    tests++;
    if (win !== 16'h1234) begin fails++; $display("FAIL left_init got %h exp 1234", win); end
`ifdef SCROLL_DIR_EN
    bus.dir = 1'b0;
`endif
    bus.run = 1'b1;
    since = 0;
    for (int t = 0; t < 5; t++) begin
      got = 0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(negedge clk); since++;
        if (bus.tick === 1'b1) got = 1;
      end
      tests++;
      if (!got || since != TICK_DIV) begin
        fails++; $display("FAIL left_period tick%0d got %0d exp %0d", t, since, TICK_DIV);
      end
      since = 0;
      @(negedge clk); since++;
      tests++;
      if (win !== exp_w[t]) begin
        fails++; $display("FAIL left_win tick%0d got %h exp %h", t, win, exp_w[t]);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_full();
    logic [3:0] codes [17];
    int ticks;
    for (int i = 0; i < 16; i++) codes[i] = 4'($urandom_range(0, 14));
    codes[16] = codes[15] ^ 4'h1;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15 || i == 16) begin
        tests++;
        if (bus.len !== LEN_W'(i) || bus.full !== (i == 16)) begin
          fails++; $display("FAIL full_fill i=%0d got len %0d full %b", i, bus.len, bus.full);
        end
      end
      bus.wr_en = 1'b1; bus.wr_data = codes[i];
    end
    @(negedge clk); bus.wr_en = 1'b0;
    tests++;
    if (bus.len !== LEN_W'(16) || bus.full !== 1'b1) begin
      fails++; $display("FAIL full_ignore got len %0d full %b exp 16 1", bus.len, bus.full);
    end
`ifdef SCROLL_DIR_EN
    bus.dir = 1'b0;
`endif
    bus.run = 1'b1;
    ticks = 0;
    for (int c = 0; c < 12 * TICK_DIV + 8 && ticks < 12; c++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) ticks++;
    end
    bus.run = 1'b0;
    @(negedge clk);
    tests++;
    if (ticks != 12 || bus.first !== codes[15] || bus.fourth !== codes[12]) begin
      fails++; $display("FAIL full_msg15 ticks %0d got first %h fourth %h exp %h %h",
                        ticks, bus.first, bus.fourth, codes[15], codes[12]);
    end
  endtask

`ifdef SCROLL_DIR_EN
  task automatic test_scroll_right();
    bit got;
    do_clear();
    write_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    bus.dir = 1'b1; bus.run = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) got = 1;
    end
    bus.run = 1'b0;
    @(negedge clk);
    tests++;
    if (!got || win !== 16'h5123) begin
      fails++; $display("FAIL right_win tick %0d got %h exp 5123", got, win);
    end
    bus.dir = 1'b0;
  endtask
`endif

  task automatic test_short_msg();
    bit got;
    do_clear();
`ifdef SCROLL_DIR_EN
    bus.dir = 1'b0;
`endif
    write_seq('{4'd7, 4'd8});
    bus.run = 1'b1;
    @(negedge clk);
    tests++;
    if (win !== 16'h7878) begin fails++; $display("FAIL short_init got %h exp 7878", win); end
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) got = 1;
    end
    @(negedge clk);
    bus.run = 1'b0;
    tests++;
    if (!got || win !== 16'h8787) begin
      fails++; $display("FAIL short_tick tick %0d got %h exp 8787", got, win);
    end
  endtask

  task automatic test_clr_with_write();
    do_clear();
    write_seq('{4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)),
                4'($urandom_range(0, 14)), 4'($urandom_range(0, 14))});
    bus.run = 1'b1;
    repeat (6) @(negedge clk);
    bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 4'h9;
    @(negedge clk);
    bus.clr = 1'b0; bus.wr_en = 1'b0;
    tests++;
    if (bus.len !== '0 || bus.full !== 1'b0 || bus.tick !== 1'b0) begin
      fails++; $display("FAIL clrwr_state got len %0d full %b tick %b exp 0 0 0",
                        bus.len, bus.full, bus.tick);
    end
    @(negedge clk);
    tests++;
    if (win !== 16'hFFFF) begin fails++; $display("FAIL clrwr_blank got %h exp ffff", win); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests++;
      if (bus.tick !== 1'b0 || win !== 16'hFFFF) begin
        fails++; $display("FAIL clrwr_idle cycle %0d got tick %b win %h exp 0 ffff", c, bus.tick, win);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      tests++;
      if (win !== m_win || bus.len !== LEN_W'(m_len) || bus.full !== m_full ||
          bus.tick !== m_tick) begin
        fails++;
        $display("FAIL random cycle %0d got win %h len %0d full %b tick %b exp %h %0d %b %b",
                 c, win, bus.len, bus.full, bus.tick, m_win, m_len, m_full, m_tick);
      end
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_data = 4'($urandom_range(0, 15));
      bus.clr     = ($urandom_range(0, 39) == 0);
      bus.run     = ($urandom_range(0, 3) != 0);
`ifdef SCROLL_DIR_EN
      bus.dir     = 1'($urandom_range(0, 1));
`endif
    end
    bus.wr_en = 1'b0; bus.clr = 1'b0; bus.run = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr     = 1'b0;
    bus.run     = 1'b0;
`ifdef SCROLL_DIR_EN
    bus.dir     = 1'b0;
`endif
    test_reset();
    test_scroll_left();
    test_full();
`ifdef SCROLL_DIR_EN
    test_scroll_right();
`endif
    test_short_msg();
    test_clr_with_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
